asconp_iter: RTL
================

Name: asconp_iter

Overview:
- Iterative, handshaked Ascon-p permutation engine with a registered 320-bit state.
- Each cycle it applies up to UROL rounds using an internal combinational round chain.
- Round count is selectable per request (1..12), so one instance serves p^12, p^8 and p^6.
- Sits between the mode controller (AEAD/hash FSM) and the state register file, replacing free-running combinational permutation use.

Parameters:
- UROL, 1, rounds computed per clock cycle; legal values 1..6.
- The final cycle of a request may apply fewer than UROL rounds.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  request valid
- in_ready_o  out  1  engine can accept a request
- rounds_i  in  4  number of rounds R to apply; sampled on accept
- x0_i..x4_i  in  64 each  input state words; sampled on accept
- out_valid_o  out  1  result valid; held until accepted
- out_ready_i  in  1  consumer accepts result
- x0_o..x4_o  out  64 each  permuted state words; registered
- busy_o  out  1  high while rounds are being computed

Behaviour:
- Reset (async assert, sync release):
  - state register, round counter and outputs all clear to 0; FSM goes to IDLE.
  - in_ready_o=1, out_valid_o=0, busy_o=0.
  - Reset mid-operation aborts the computation with no output.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o: latch state, and latch Reff = min(rounds_i,12).
  - Set the round index r = 12-Reff, the Ascon round index of the first round.
  - Go to BUSY if Reff>0. If Reff==0, go to DONE with the state unchanged.
- BUSY:
  - Each cycle apply n = min(UROL, 12-r) rounds with indices r..r+n-1, then r += n.
  - Stages beyond n are bypassed: the chain output is muxed from stage n.
  - When r reaches 12, register the result and go to DONE.
  - in_ready_o=0, busy_o=1.
- DONE:
  - out_valid_o=1; x*_o stay stable.
  - On out_ready_i, go to IDLE; out_valid_o drops the next cycle.
  - in_ready_o=0. Back-to-back requests cost one IDLE cycle.
- Round function for round index k (0..11):
  - Constant c = {4'hF-k, k[3:0]} (8 bits), XORed into x2 bits [7:0]. k=0 gives 0xF0; k=11 gives 0x4B.
  - Order: affine-1, chi, affine-2, linear.
  - Linear rotation amounts (right rotations): x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
  - Round-index arithmetic is 4-bit unsigned; r never exceeds 12.
- Latency, accept edge to out_valid_o high: ceil(Reff/UROL) cycles when Reff>0; 1 cycle when Reff==0.
  - Example: p^12 with UROL=1 takes 12 cycles; with UROL=4 it takes 3 cycles.
  - Example: p^6 with UROL=4 takes 2 cycles (4 rounds, then 2).
- Input ports are don't-care outside the accept cycle.
- x*_o hold the last result in IDLE until the next result overwrites them.
- rounds_i >12 is clamped to 12 silently.

Test Plan:
- Single round, zero state:
  - Stimulus: UROL=1, rounds_i=1, all-zero state.
  - Required: out_valid_o exactly 1 cycle after accept.
  - x0=0x001E0F00000000F0, x1=0x00000001E0000870, x2=0x3FFFFFFFFFFFFF74, x3=0x3C780000000000F0, x4=0.
- p^12/p^8/p^6 versus golden model:
  - Stimulus: random states, run for each UROL in {1,2,3,4,5,6}.
  - Required: outputs bit-exact to a software Ascon-p.
  - Required latencies for UROL=5: 3, 2 and 2 cycles respectively.
- Boundaries:
  - rounds_i=0: output equals input, out_valid_o after 1 cycle.
  - rounds_i=15: result and latency identical to rounds_i=12.
- Backpressure:
  - Stimulus: hold out_ready_i=0 for 10 cycles in DONE.
  - Required: out_valid_o stays 1, x*_o stable, in_ready_o=0, no new accept.
  - Release: accept happens on the release cycle; in_ready_o=1 on the next cycle.
- Reset mid-BUSY:
  - Stimulus: assert rst_n=0 asynchronously during a p^12 run.
  - Required: outputs zero immediately, in_ready_o=1 after release.
  - Required: a new p^6 request then completes correctly.

Source files
------------

// File: rtl/asconp_iter.sv
// Iterative Ascon-p permutation engine: one registered 320-bit state, UROL rounds
// per clock through a combinational round chain, valid/ready on both sides.
module asconp_iter #(
  parameter int unsigned UROL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0][63:0]   st_q;
  logic [4:0][63:0]   xo_q;
  logic [3:0]         r_q;
  logic [3:0]         reff;
  logic [3:0]         rem;
  logic [3:0]         n_rnd;
  logic               last;
  logic [4:0][63:0]   chain_out;
  logic [4:0][63:0]   stage [UROL+1];

  function automatic logic [4:0][63:0] asc_round(input logic [4:0][63:0] s,
                                                 input logic [3:0]       k);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [4:0][63:0] r;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, 4'hF - k, k};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    r[1] = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    r[2] = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    r[3] = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    r[4] = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return r;
  endfunction

  assign reff  = (rounds_i > 4'd12) ? 4'd12 : rounds_i;
  assign rem   = 4'd12 - r_q;
  assign n_rnd = (rem < 4'(UROL)) ? rem : 4'(UROL);
  assign last  = ((r_q + n_rnd) == 4'd12);

  // Stages past n_rnd still evaluate but are bypassed by the output mux.
  always_comb begin
    stage[0]  = st_q;
    for (int unsigned i = 0; i < UROL; i++) begin
      stage[i+1] = asc_round(stage[i], r_q + 4'(i));
    end
    chain_out = st_q;
    for (int unsigned i = 0; i <= UROL; i++) begin
      if (4'(i) == n_rnd) chain_out = stage[i];
    end
  end

  // A zero-round request still takes one pass through BUSY (chain fully
  // bypassed), giving it the same one-cycle latency as a single chunk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      xo_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            st_q <= {x4_i, x3_i, x2_i, x1_i, x0_i};
            r_q  <= 4'd12 - reff;
          end
        end
        BUSY: begin
          st_q <= chain_out;
          r_q  <= r_q + n_rnd;
          if (last) xo_q <= chain_out;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == BUSY);
  assign out_valid_o = (state_q == DONE);
  assign x0_o        = xo_q[0];
  assign x1_o        = xo_q[1];
  assign x2_o        = xo_q[2];
  assign x3_o        = xo_q[3];
  assign x4_o        = xo_q[4];

endmodule
